// File: rtl/bcd_to_byte_seq_pkg.sv
// Shared constants and FSM encoding for the sequential BCD-to-binary converter.
// Typed constants keep digit comparisons at their natural 4-bit width.
package bcd_to_byte_seq_pkg;

  localparam int          BCD_DIGIT_W    = 4;
  localparam logic [3:0]  BCD_MAX_DIGIT  = 4'd9;
  localparam logic [3:0]  BCD_ADJ_THRESH = 4'd8;
  localparam logic [3:0]  BCD_ADJ_VAL    = 4'd3;
  localparam logic [7:0]  BYTE_MAX       = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Reverse double-dabble correction for one BCD digit: after a right shift,
// a digit of 8 or more carries a spilled half-ten and is brought back down by 3.
module bcd_digit_adjust
  import bcd_to_byte_seq_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  always_comb begin
    dout = din;
    if (din >= BCD_ADJ_THRESH) dout = din - BCD_ADJ_VAL;
  end

endmodule

// File: rtl/bcd_to_byte_seq.sv
// Iterative BCD-to-binary converter: one right shift plus digit correction per clock,
// with a start/busy/done handshake and a byte-saturated copy of the result.
module bcd_to_byte_seq
  import bcd_to_byte_seq_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_in,
  output logic                          busy,
  output logic                          done,
  output logic [BIN_W-1:0]              bin_out,
  output logic [7:0]                    byte_out,
  output logic                          ovf,
  output logic                          err
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  state_t            state, state_nxt;
  logic [SR_W-1:0]   sr, sr_shift, sr_adj;
  logic [CNT_W-1:0]  cnt;
  logic              err_q;
  logic              bad_digit;
  logic              accept;
  logic              last;
  logic [BIN_W-1:0]  bin_nxt;
  logic              ovf_nxt;

  // Busy/done come straight off the state register, so both are glitch-free.
  assign busy   = (state == CONV);
  assign done   = (state == FIN);
  assign accept = start && !busy;
  assign last   = (state == CONV) && (cnt == CNT_W'(BIN_W - 1));

  assign sr_shift = sr >> 1;
  assign sr_adj[BIN_W-1:0] = sr_shift[BIN_W-1:0];

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .din  (sr_shift[BIN_W + g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .dout (sr_adj  [BIN_W + g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (bcd_in[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_MAX_DIGIT) bad_digit = 1'b1;
  end

  // Bad input zeroes the result but keeps the same timing as a good one.
  always_comb begin
    bin_nxt = err_q ? '0 : sr_adj[BIN_W-1:0];
    ovf_nxt = |bin_nxt[BIN_W-1:8];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CONV;
      CONV:    if (last)  state_nxt = FIN;
      FIN:     state_nxt = start ? CONV : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      sr       <= '0;
      cnt      <= '0;
      err_q    <= 1'b0;
      bin_out  <= '0;
      byte_out <= '0;
      ovf      <= 1'b0;
      err      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        sr    <= {bcd_in, {BIN_W{1'b0}}};
        cnt   <= '0;
        err_q <= bad_digit;
      end else if (state == CONV) begin
        sr  <= sr_adj;
        cnt <= cnt + 1'b1;
        if (last) begin
          bin_out  <= bin_nxt;
          ovf      <= ovf_nxt;
          byte_out <= ovf_nxt ? BYTE_MAX : bin_nxt[7:0];
          err      <= err_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_to_byte_seq.sv
// Directed bench for bcd_to_byte_seq: hand-computed vectors, handshake corner cases
// and a full sweep of valid 3-digit BCD inputs.
module tb_bcd_to_byte_seq;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [11:0] bcd_in;
  logic        busy, done, ovf, err;
  logic [9:0]  bin_out;
  logic [7:0]  byte_out;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bcd_to_byte_seq dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bcd_in   (bcd_in),
    .busy     (busy),
    .done     (done),
    .bin_out  (bin_out),
    .byte_out (byte_out),
    .ovf      (ovf),
    .err      (err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Called #1 after an edge with the DUT able to accept; returns #1 after the accept edge.
  task automatic start_conv(input logic [11:0] v);
    start  = 1'b1;
    bcd_in = v;
    @(posedge clk); #1;
    start  = 1'b0;
    bcd_in = 12'hFFF;
  endtask

  // lat = cycles from the start-asserting cycle to the done cycle; 0 on timeout.
  task automatic wait_done(output int lat, output int busy_cyc);
    lat = 0;
    busy_cyc = 0;
    for (int k = 0; k < 30; k++) begin
      if (done) begin
        lat = k + 1;
        break;
      end
      if (busy) busy_cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_res(input string tag, input int bin, input int byt,
                           input logic o, input logic e);
    chk({tag, ".bin"},  bin_out, bin);
    chk({tag, ".byte"}, byte_out, byt);
    chk({tag, ".ovf"},  ovf, o);
    chk({tag, ".err"},  err, e);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bc, dn, val, exp_byte;
    logic [11:0] v;

    reset = 1'b1; start = 1'b0; bcd_in = '0;
    tick(2);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    check_res("rst", 0, 0, 1'b0, 1'b0);
    reset = 1'b0;
    tick(1);

    // 1: 255, also check latency and busy width
    start_conv(12'h255);
    wait_done(lat, bc);
    chk("t1.lat", lat, 11);
    chk("t1.busy_cyc", bc, 10);
    chk("t1.busy_in_fin", busy, 0);
    check_res("t1", 255, 255, 1'b0, 1'b0);
    tick(1);
    chk("t1.done_pulse", done, 0);
    chk("t1.hold", bin_out, 255);

    // 2: 999 saturates
    start_conv(12'h999);
    wait_done(lat, bc);
    chk("t2.lat", lat, 11);
    check_res("t2", 999, 255, 1'b1, 1'b0);
    tick(1);

    // 3: zero and the first value past a byte
    start_conv(12'h000);
    wait_done(lat, bc);
    check_res("t3a", 0, 0, 1'b0, 1'b0);
    tick(1);
    start_conv(12'h256);
    wait_done(lat, bc);
    check_res("t3b", 256, 255, 1'b1, 1'b0);
    tick(1);

    // 4: bad digit
    start_conv(12'h1A3);
    wait_done(lat, bc);
    chk("t4.lat", lat, 11);
    check_res("t4", 0, 0, 1'b0, 1'b1);
    tick(1);

    // 5a: start while busy is ignored
    start_conv(12'h128);
    tick(2);
    start = 1'b1; bcd_in = 12'h050;
    tick(1);
    start = 1'b0;
    wait_done(lat, bc);
    chk("t5a.lat", lat, 8);
    check_res("t5a", 128, 128, 1'b0, 1'b0);
    tick(1);

    // 5b: reset mid-conversion
    start_conv(12'h321);
    tick(4);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("t5b.busy", busy, 0);
    chk("t5b.done", done, 0);
    check_res("t5b", 0, 0, 1'b0, 1'b0);
    dn = 0;
    for (int k = 0; k < 15; k++) begin
      if (done) dn++;
      tick(1);
    end
    chk("t5b.no_done", dn, 0);

    // reset and start together: reset wins
    reset = 1'b1; start = 1'b1; bcd_in = 12'h111;
    tick(1);
    reset = 1'b0; start = 1'b0;
    chk("t5c.busy", busy, 0);
    tick(1);

    // 5d: start in the FIN cycle
    start_conv(12'h042);
    wait_done(lat, bc);
    check_res("t5d.a", 42, 42, 1'b0, 1'b0);
    start_conv(12'h777);
    chk("t5d.busy", busy, 1);
    chk("t5d.hold", bin_out, 42);
    wait_done(lat, bc);
    chk("t5d.lat", lat, 11);
    check_res("t5d.b", 777, 255, 1'b1, 1'b0);
    tick(1);

    // 6: sweep with random idle gaps
    for (int i = 0; i < 1000; i++) begin
      v = {4'(i / 100), 4'((i / 10) % 10), 4'(i % 10)};
      start_conv(v);
      wait_done(lat, bc);
      val = i;
      exp_byte = (val > 255) ? 255 : val;
      chk("sw.bin", bin_out, val);
      chk("sw.byte", byte_out, exp_byte);
      chk("sw.ovf", ovf, (val > 255) ? 1 : 0);
      tick($urandom_range(0, 3));
      if (done) tick(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
